// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, with a valid/ready request side
// and a registered result side that carries a zero flag and a tag.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [TAG_W-1:0] tag_out
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned ACC_W = 2 * WIDTH;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   amag_q, amag_d;
   logic [WIDTH-1:0]   bmag_q, bmag_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               zero_q, zero_d;
   logic [TAG_W-1:0]   tago_q, tago_d;
   logic               ovalid_q, ovalid_d;

   // Operand sign/magnitude decode for the request being presented
   logic             a_signed, b_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign a_signed = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
   assign b_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign a_neg    = a_signed && operand_a[WIDTH-1];
   assign b_neg    = b_signed && operand_b[WIDTH-1];
   assign a_mag    = a_neg ? -operand_a : operand_a;
   assign b_mag    = b_neg ? -operand_b : operand_b;

   assign in_ready  = (state_q == IDLE) && !flush;
   assign out_valid = ovalid_q;
   assign result    = res_q;
   assign zero      = zero_q;
   assign tag_out   = tago_q;

   logic             fast;
   logic [WIDTH-1:0] fast_res;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   shifted;
   logic [ACC_W-1:0] prod;
   logic [WIDTH-1:0] quo_s, rem_s, fix_res;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      tag_d    = tag_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      amag_d   = amag_q;
      bmag_d   = bmag_q;
      acc_d    = acc_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      zero_d   = zero_q;
      tago_d   = tago_q;
      ovalid_d = ovalid_q;
      fast     = 1'b0;
      fast_res = '0;
      mul_sum  = '0;
      shifted  = '0;
      prod     = '0;
      quo_s    = '0;
      rem_s    = '0;
      fix_res  = '0;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               op_d   = op;
               tag_d  = tag_in;
               neg_d  = a_neg ^ b_neg;
               rneg_d = a_neg;
               amag_d = a_mag;
               bmag_d = b_mag;
               acc_d  = {{WIDTH{1'b0}}, b_mag};
               quo_d  = a_mag;
               rem_d  = '0;
               cnt_d  = '0;
               // Divide-by-zero and signed overflow resolve without iterating
               if (op[2] && (operand_b == '0)) begin
                  fast     = 1'b1;
                  fast_res = op[1] ? operand_a : '1;
               end else if (((op == OP_DIV) || (op == OP_REM)) &&
                            (operand_a == MIN_NEG) && (operand_b == '1)) begin
                  fast     = 1'b1;
                  fast_res = op[1] ? '0 : operand_a;
               end
               if (fast) begin
                  res_d    = fast_res;
                  zero_d   = (fast_res == '0);
                  tago_d   = tag_in;
                  ovalid_d = 1'b1;
                  state_d  = DONE;
               end else begin
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            if (!op_q[2]) begin
               // Shift-add: the multiplier occupies the low half and drains out to the right
               mul_sum = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, (acc_q[0] ? amag_q : '0)};
               acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
            end else begin
               shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
               if (shifted >= {1'b0, bmag_q}) begin
                  rem_d = shifted - {1'b0, bmag_q};
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = shifted;
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            prod  = neg_q ? -acc_q : acc_q;
            quo_s = neg_q ? -quo_q : quo_q;
            rem_s = rneg_q ? -WIDTH'(rem_q) : WIDTH'(rem_q);
            case (op_q)
               OP_MUL:                       fix_res = prod[WIDTH-1:0];
               OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[ACC_W-1:WIDTH];
               OP_DIV, OP_DIVU:              fix_res = quo_s;
               default:                      fix_res = rem_s;
            endcase
            res_d    = fix_res;
            zero_d   = (fix_res == '0);
            tago_d   = tag_q;
            ovalid_d = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: begin
            ovalid_d = 1'b0;
            state_d  = IDLE;
         end
      endcase

      if (flush) begin
         ovalid_d = 1'b0;
         state_d  = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         tag_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         amag_q   <= '0;
         bmag_q   <= '0;
         acc_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         zero_q   <= 1'b1;
         tago_q   <= '0;
         ovalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         amag_q   <= amag_d;
         bmag_q   <= bmag_d;
         acc_q    <= acc_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         zero_q   <= zero_d;
         tago_q   <= tago_d;
         ovalid_q <= ovalid_d;
      end
   end

endmodule
